// File: rtl/crc12_pkg.sv
// Shared CRC-12 constants and checker FSM state type; also used by the
// upstream nibble-to-codeword CRC generator so both sides agree on the polynomial.
package crc12_pkg;

    localparam int CRC12_W = 12;
    localparam int NIB_W   = 4;
    localparam int CW_W    = 16;

    // x^12+x^11+x^3+x^2+x+1, implicit x^12 term
    localparam logic [CRC12_W-1:0] CRC12_POLY = 12'h80F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/crc12_checker_if.sv
// Serial codeword input stream and decoded-frame output handshake of crc12_checker.
interface crc12_checker_if;
    import crc12_pkg::*;

    logic             s_valid;
    logic             s_sof;
    logic             s_bit;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic [NIB_W-1:0] m_data;
    logic             m_crc_ok;

    modport master (
        output s_valid, s_sof, s_bit, m_ready,
        input  s_ready, m_valid, m_data, m_crc_ok
    );

    modport slave (
        input  s_valid, s_sof, s_bit, m_ready,
        output s_ready, m_valid, m_data, m_crc_ok
    );

endinterface

// File: rtl/crc12_lfsr.sv
// Serial CRC-12 divider. rem is the remainder including the bit on din this
// cycle, so the caller can judge a codeword on the edge that accepts its last bit.
module crc12_lfsr
    import crc12_pkg::*;
#(
    parameter logic [CRC12_W-1:0] POLY = CRC12_POLY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               din,
    output logic [CRC12_W-1:0] rem
);

    logic [CRC12_W-1:0] r;
    logic [CRC12_W-1:0] base;

    // clr seeds from zero in the same cycle as the first bit is shifted in
    always_comb begin
        base = clr ? '0 : r;
        rem  = {base[CRC12_W-2:0], din} ^ (base[CRC12_W-1] ? POLY : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r <= '0;
        end else if (en) begin
            r <= rem;
        end
    end

endmodule

// File: rtl/crc12_checker.sv
// Serial CRC-12 codeword checker: recovers the 4-bit nibble and flags remainder errors.
// Optional failed-frame counter built only when CRC12_CHECKER_ERRCNT_EN is defined.
module crc12_checker
    import crc12_pkg::*;
#(
    parameter logic [CRC12_W-1:0] POLY = CRC12_POLY
) (
    input  logic                  clk,
    input  logic                  rst,
    crc12_checker_if.slave        bus,
    output logic [7:0]            err_cnt
);

    localparam logic [3:0] NIB_LAST = 4'(NIB_W - 1);
    localparam logic [3:0] CW_LAST  = 4'(CW_W - 1);

    state_t             state, state_nxt;
    logic [3:0]         count, count_nxt;
    logic [NIB_W-1:0]   nib, nib_nxt;
    logic               xfer;
    logic               load;
    logic               last;
    logic               lfsr_en;
    logic [CRC12_W-1:0] rem;

    assign bus.s_ready = (state != HOLD);
    assign xfer        = bus.s_valid && bus.s_ready;

    crc12_lfsr #(.POLY(POLY)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  (lfsr_en),
        .din (bus.s_bit),
        .rem (rem)
    );

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        nib_nxt   = nib;
        load      = 1'b0;
        last      = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer && bus.s_sof) begin
                    load      = 1'b1;
                    lfsr_en   = 1'b1;
                    state_nxt = SHIFT;
                    count_nxt = 4'd1;
                    nib_nxt   = {{(NIB_W-1){1'b0}}, bus.s_bit};
                end
            end
            SHIFT: begin
                if (xfer) begin
                    lfsr_en = 1'b1;
                    // a fresh s_sof abandons the partial frame silently
                    if (bus.s_sof) begin
                        load      = 1'b1;
                        count_nxt = 4'd1;
                        nib_nxt   = {{(NIB_W-1){1'b0}}, bus.s_bit};
                    end else begin
                        if (count <= NIB_LAST) begin
                            nib_nxt = {nib[NIB_W-2:0], bus.s_bit};
                        end
                        if (count == CW_LAST) begin
                            last      = 1'b1;
                            state_nxt = HOLD;
                            count_nxt = 4'd0;
                        end else begin
                            count_nxt = count + 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            nib          <= '0;
            bus.m_valid  <= 1'b0;
            bus.m_data   <= '0;
            bus.m_crc_ok <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            nib   <= nib_nxt;
            if (last) begin
                bus.m_valid  <= 1'b1;
                bus.m_data   <= nib;
                bus.m_crc_ok <= (rem == '0);
            end else if (state == HOLD && bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
        end
    end

`ifdef CRC12_CHECKER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= 8'h00;
        end else if (last && (rem != '0) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_crc12_checker.sv
// Randomized scoreboard bench for crc12_checker; expected frames come from a
// polynomial-division reference model and are checked by an independent monitor.
module tb_crc12_checker;
    import crc12_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] err_cnt;

    crc12_checker_if bus();

    crc12_checker dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] nib;
        logic       ok;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   err_model  = 0;

    // Remainder of the 16-bit codeword polynomial modulo x^12+x^11+x^3+x^2+x+1
    function automatic logic [11:0] poly_mod(input logic [15:0] cw);
        logic [15:0] v;
        v = cw;
        for (int i = 15; i >= 12; i--) begin
            if (v[i]) v = v ^ (16'h180F << (i - 12));
        end
        return v[11:0];
    endfunction

    function automatic logic [15:0] encode(input logic [3:0] nib);
        return {nib, poly_mod({nib, 12'h000})};
    endfunction

    function automatic int exp_err();
`ifdef CRC12_CHECKER_ERRCNT_EN
        return err_model;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks HOLD stability
    logic       hold_seen = 1'b0;
    logic [3:0] hold_data;
    logic       hold_ok;
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.m_valid) begin
            if (hold_seen) begin
                check("hold_m_data", bus.m_data, hold_data);
                check("hold_m_crc_ok", bus.m_crc_ok, hold_ok);
            end
            hold_seen = 1'b1;
            hold_data = bus.m_data;
            hold_ok   = bus.m_crc_ok;
            if (bus.m_ready) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: got data %0h ok %0b, expected no frame", bus.m_data, bus.m_crc_ok);
                end else begin
                    e = q.pop_front();
                    check("m_data", bus.m_data, e.nib);
                    check("m_crc_ok", bus.m_crc_ok, e.ok);
                end
                hold_seen = 1'b0;
            end
        end else begin
            hold_seen = 1'b0;
        end
    end

    task automatic send_bit(input logic sof, input logic b, input int gap_max);
        int   gaps;
        int   waited;
        logic rdy;
        gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        bus.s_valid = 1'b0;
        repeat (gaps) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_bit   = b;
        waited = 0;
        do begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 200);
        if (!rdy) check("s_ready_timeout", 0, 1);
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] cw, input int gap_max, input bit push);
        exp_t e;
        if (push) begin
            e.nib = cw[15:12];
            e.ok  = (poly_mod(cw) == 12'h000);
            q.push_back(e);
            if (!e.ok && err_model < 255) err_model++;
        end
        for (int i = 15; i >= 0; i--) send_bit(i == 15, cw[i], gap_max);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_data"}, bus.m_data, 0);
        check({tag, "_m_crc_ok"}, bus.m_crc_ok, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_s_ready"}, bus.s_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cw;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_bit   = 1'b0;
        bus.m_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_zero_outputs("reset");

        // Known codeword with nibble 1; m_valid must be up right after the last bit's edge
        send_frame(16'h180F, 0, 1);
        check("latency_m_valid", bus.m_valid, 1);
        drain();
        check("err_cnt_good", err_cnt, exp_err());

        send_frame(16'h0000, 0, 1);
        send_frame(16'h180E, 0, 1);
        drain();
        check("err_cnt_one_bad", err_cnt, exp_err());

        // All nibbles back-to-back with random gaps
        for (int n = 0; n < 16; n++) send_frame(encode(4'(n)), 3, 1);
        drain();
        check("err_cnt_all_nibbles", err_cnt, exp_err());

        // Random nibbles, half of them with a single flipped bit
        for (int n = 0; n < 20; n++) begin
            cw = encode(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) cw = cw ^ (16'h0001 << $urandom_range(0, 15));
            send_frame(cw, 2, 1);
        end
        drain();
        check("err_cnt_random", err_cnt, exp_err());

        // Downstream stall in HOLD with input pressure
        bus.m_ready = 1'b0;
        send_frame(encode(4'hA), 0, 1);
        bus.s_valid = 1'b1;
        bus.s_sof   = 1'b1;
        bus.s_bit   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("stall_s_ready", bus.s_ready, 0);
            check("stall_m_valid", bus.m_valid, 1);
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.m_ready = 1'b1;
        send_frame(encode(4'h5), 0, 1);
        drain();

        // Abort after 9 bits, then a complete valid frame
        cw = encode(4'h7);
        for (int i = 15; i >= 7; i--) send_bit(i == 15, cw[i], 1);
        send_frame(16'h180F, 0, 1);
        drain();

        // Reset mid-frame
        cw = encode(4'h3);
        for (int i = 15; i >= 10; i--) send_bit(i == 15, cw[i], 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        err_model = 0;
        check_zero_outputs("rst_shift");

        // Bits without s_sof after reset must be ignored
        cw = encode(4'hC);
        for (int i = 15; i >= 0; i--) send_bit(1'b0, cw[i], 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("no_sof_m_valid", bus.m_valid, 0);

        // Reset while holding a corrupted frame
        bus.m_ready = 1'b0;
        send_frame(encode(4'h9) ^ 16'h0001, 0, 0);
        check("hold_before_rst", bus.m_valid, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.m_ready = 1'b1;
        err_model = 0;
        check_zero_outputs("rst_hold");
        send_frame(encode(4'h2), 1, 1);
        drain();

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            cw = encode(4'($urandom_range(0, 15))) ^ (16'h0001 << $urandom_range(0, 15));
            send_frame(cw, 0, 1);
        end
        drain();
        check("err_cnt_saturate", err_cnt, exp_err());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/crc12_checker.md
CRC12_CHECKER -- requirements
Module: crc12_checker

Interface
REQ-001 Parameter: POLY, default 12'h80F, CRC-12 generator polynomial x^12+x^11+x^3+x^2+x+1 with the implicit x^12 term.
REQ-002 Port: clk  in  1  clock; all logic rising-edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-low.
REQ-004 Port: s_valid  in  1  serial bit valid.
REQ-005 Port: s_sof  in  1  start-of-frame; qualifies the codeword MSB (bit 15).
REQ-006 Port: s_bit  in  1  serial codeword bit, MSB first.
REQ-007 Port: s_ready  out  1  checker accepts a bit this cycle.
REQ-008 Port: m_valid  out  1  decoded frame available.
REQ-009 Port: m_ready  in  1  downstream accepts frame.
REQ-010 Port: m_data  out  4  recovered nibble, codeword bits 15:12.
REQ-011 Port: m_crc_ok  out  1  final remainder equals zero.
REQ-012 Port: err_cnt  out  8  count of failed frames.

Function
REQ-013 Input codeword is 16 bits: {nibble[3:0], crc[11:0]}; a bit transfers when s_valid && s_ready.
REQ-014 FSM states: IDLE, SHIFT, HOLD; s_ready = (state != HOLD).
REQ-015 IDLE: a transfer with s_sof=1 loads bit 15, seeds the LFSR, sets bit count to 1, and moves to SHIFT; transfers with s_sof=0 are discarded.
REQ-016 LFSR update per accepted bit: r <= {r[10:0], s_bit} ^ (r[11] ? POLY : 12'h000); the seed is 12'h000.
REQ-017 SHIFT: each transfer shifts in one bit; bits 15:12 are also captured into a nibble register.
REQ-018 SHIFT, transfer with s_sof=1: abort the current frame and restart as in REQ-015 using that bit; the aborted frame produces no output.
REQ-019 SHIFT: the 16th accepted bit moves the FSM to HOLD on the next edge; m_valid=1, m_data=nibble, m_crc_ok=(final r == 0).
REQ-020 HOLD: m_valid, m_data, and m_crc_ok stay stable until m_ready=1; then the next edge clears m_valid and moves to IDLE.
REQ-021 Latency: m_valid rises on the edge that accepts bit 0; minimum frame period is 17 cycles with m_ready held at 1.
REQ-022 Gaps (s_valid=0) in SHIFT hold all state; there is no timeout.
REQ-023 err_cnt increments on the HOLD-entry edge when the remainder is nonzero, and saturates at 8'hFF.

Reset
REQ-024 When rst=0 at a clock edge, the following values load: state=IDLE, LFSR=0, count=0, m_valid=0, m_data=0, m_crc_ok=0, err_cnt=0. s_ready is 1 after reset.
REQ-025 Reset mid-frame or in HOLD discards the frame without emitting output; the first post-reset frame requires s_sof.

Configuration
REQ-026 Macro CRC12_CHECKER_ERRCNT_EN defined: err_cnt behaves per REQ-023.
REQ-027 Macro CRC12_CHECKER_ERRCNT_EN undefined: no counter logic is built; the err_cnt port remains and is driven constant 8'h00.

Structure
REQ-028 Package crc12_pkg holds: CRC12_POLY=12'h80F, CRC12_W=12, NIB_W=4, CW_W=16, and the FSM state enum type.
REQ-029 Sub-module crc12_lfsr, a 12-bit serial LFSR with clear, enable, and bit inputs and a remainder output, is instantiated once.
REQ-030 The package is shared with the upstream nibble-to-codeword CRC generator, so both sides use one polynomial constant.

Verification
REQ-031 Codeword 16'h180F (nibble 1), m_ready=1 -> m_valid after bit 0; m_data=4'h1, m_crc_ok=1, err_cnt=0.
REQ-032 Codeword 16'h0000 -> m_data=4'h0, m_crc_ok=1; codeword 16'h180E -> m_crc_ok=0, err_cnt=1 (macro defined) or 0 (undefined).
REQ-033 All 16 nibbles encoded with the reference model, sent back-to-back, with random s_valid gaps -> 16 frames, all m_crc_ok=1, data matches in order.
REQ-034 m_ready=0 for 10 cycles in HOLD while s_valid=1 -> s_ready=0, outputs stable, no bits consumed; release -> next frame is decoded correctly.
REQ-035 s_sof re-asserted after 9 bits with valid codeword 16'h180F following -> exactly one output (4'h1, ok); rst=0 mid-frame -> no output, all outputs zero.
REQ-036 300 corrupted frames with macro defined -> err_cnt saturates at 8'hFF.
